// File: rtl/axi4_protocol_checker.sv
// -----------------------------------------------------------------------------
// axi4_protocol_checker
//
// Passive AXI4 protocol checker for one master/slave link. It taps all five
// channels and raises sticky error flags for:
//   bit 0..4 : VALID/payload stability violation on AW, W, B, AR, R
//   bit 5    : WLAST does not match the burst length of the owning AW
//   bit 6    : W handshake with no outstanding (or coincident) AW
//   bit 7    : B handshake with no completed write, or BID mismatch
//   bit 8    : R handshake with no outstanding AR, RID mismatch or RLAST error
//   bit 9    : AW or AR handshake while the tracking FIFO is full
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   chk_en                while low no error bit sets (tracking still runs)
//   err_clr               clears err_sticky, first_err and err_cnt
//   AW*/W*/B*/AR*/R*      AXI4 channel taps (all inputs)
//   err_sticky[9:0]       sticky error bits
//   err_any               OR of err_sticky
//   first_err[3:0]        index of first error since reset/clear, 4'hF = none
//   err_cnt[7:0]          cycles with at least one new error, saturating
//
// Errors are computed from the inputs sampled at a clock edge and appear on the
// outputs right after that edge.
// -----------------------------------------------------------------------------
module axi4_protocol_checker #(
  parameter int ID_WIDTH        = 9,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    chk_en,
  input  logic                    err_clr,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [LEN_WIDTH-1:0]    AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  input  logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  input  logic                    WREADY,
  input  logic [ID_WIDTH-1:0]     BID,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [LEN_WIDTH-1:0]    ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     RID,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  input  logic                    RREADY,
  output logic [9:0]              err_sticky,
  output logic                    err_any,
  output logic [3:0]              first_err,
  output logic [7:0]              err_cnt
);

  localparam int IDX_W = $clog2(MAX_OUTSTANDING);
  // One extra pointer bit distinguishes full from empty.
  localparam int PTR_W = IDX_W + 1;
  // One extra bit so len = 2^LEN_WIDTH-1 can be counted without wrapping.
  localparam int CNT_W = LEN_WIDTH + 1;

  localparam int AX_W  = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 5;
  localparam int WP_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int BP_W  = ID_WIDTH + 2;
  localparam int RP_W  = ID_WIDTH + DATA_WIDTH + 3;
  localparam int M1_W  = (AX_W > WP_W) ? AX_W : WP_W;
  localparam int M2_W  = (BP_W > RP_W) ? BP_W : RP_W;
  localparam int P_W   = (M1_W > M2_W) ? M1_W : M2_W;

  // ---------------------------------------------------------------------------
  // Stability: every channel is zero-extended to a common width so one
  // generated checker serves all five.
  // ---------------------------------------------------------------------------
  logic [4:0][P_W-1:0] pay;
  logic [4:0]          vld;
  logic [4:0]          rdy;
  logic [4:0]          stab_err;

  assign pay[0] = P_W'({AWID, AWADDR, AWLEN, AWSIZE, AWBURST});
  assign pay[1] = P_W'({WDATA, WSTRB, WLAST});
  assign pay[2] = P_W'({BID, BRESP});
  assign pay[3] = P_W'({ARID, ARADDR, ARLEN, ARSIZE, ARBURST});
  assign pay[4] = P_W'({RID, RDATA, RRESP, RLAST});
  assign vld    = {RVALID, ARVALID, BVALID, WVALID, AWVALID};
  assign rdy    = {RREADY, ARREADY, BREADY, WREADY, AWREADY};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stab
      logic           hold_vld_reg;
      logic [P_W-1:0] hold_pay_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          hold_vld_reg <= 1'b0;
          hold_pay_reg <= '0;
        end else begin
          hold_vld_reg <= vld[gi] && !rdy[gi];
          hold_pay_reg <= pay[gi];
        end
      end

      assign stab_err[gi] = hold_vld_reg && (!vld[gi] || (pay[gi] != hold_pay_reg));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Write tracking. One FIFO, three pointers:
  //   aw_wr_ptr : next free slot (AW push)
  //   w_ptr     : burst currently receiving data
  //   b_ptr     : oldest write awaiting its response (pop)
  // ---------------------------------------------------------------------------
  logic [ID_WIDTH-1:0]  aw_id_mem  [MAX_OUTSTANDING];
  logic [LEN_WIDTH-1:0] aw_len_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     aw_wr_ptr_reg, w_ptr_reg, b_ptr_reg;
  logic [CNT_W-1:0]     wbeat_reg;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;

  logic                 aw_full, aw_push;
  logic                 w_pending, w_has, w_adv;
  logic [LEN_WIDTH-1:0] w_len;
  logic                 w_last_err, w_orphan_err;
  logic                 b_has, b_pop, b_err;

  assign aw_full   = (aw_wr_ptr_reg - b_ptr_reg) == PTR_W'(MAX_OUTSTANDING);
  assign aw_push   = aw_hs && !aw_full;
  assign w_pending = w_ptr_reg != aw_wr_ptr_reg;
  // A coincident AW counts as preceding its first W beat; its length then
  // comes straight from the bus because it is not in the FIFO yet.
  assign w_has     = w_pending || aw_push;
  assign w_len     = w_pending ? aw_len_mem[w_ptr_reg[IDX_W-1:0]] : AWLEN;
  assign w_last_err   = w_hs && w_has && (WLAST != (wbeat_reg == {1'b0, w_len}));
  assign w_orphan_err = w_hs && !w_has;
  assign w_adv        = w_hs && w_has && WLAST;

  // Only writes whose data has completed may be responded to, in order.
  assign b_has = b_ptr_reg != w_ptr_reg;
  assign b_pop = b_hs && b_has;
  assign b_err = b_hs && (!b_has || (BID != aw_id_mem[b_ptr_reg[IDX_W-1:0]]));

  always_ff @(posedge clk) begin
    if (aw_push) begin
      aw_id_mem[aw_wr_ptr_reg[IDX_W-1:0]]  <= AWID;
      aw_len_mem[aw_wr_ptr_reg[IDX_W-1:0]] <= AWLEN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_wr_ptr_reg <= '0;
      w_ptr_reg     <= '0;
      b_ptr_reg     <= '0;
      wbeat_reg     <= '0;
    end else begin
      if (aw_push) aw_wr_ptr_reg <= aw_wr_ptr_reg + PTR_W'(1);
      if (w_adv)   w_ptr_reg     <= w_ptr_reg + PTR_W'(1);
      if (b_pop)   b_ptr_reg     <= b_ptr_reg + PTR_W'(1);
      if (w_hs && w_has) begin
        wbeat_reg <= WLAST ? '0 : wbeat_reg + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read tracking: plain FIFO, popped on the RLAST handshake.
  // ---------------------------------------------------------------------------
  logic [ID_WIDTH-1:0]  ar_id_mem  [MAX_OUTSTANDING];
  logic [LEN_WIDTH-1:0] ar_len_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     ar_wr_ptr_reg, ar_rd_ptr_reg;
  logic [CNT_W-1:0]     rbeat_reg;

  logic                 ar_full, ar_push, r_has, r_pop, r_err;
  logic [ID_WIDTH-1:0]  r_head_id;
  logic [LEN_WIDTH-1:0] r_head_len;

  assign ar_full    = (ar_wr_ptr_reg - ar_rd_ptr_reg) == PTR_W'(MAX_OUTSTANDING);
  assign ar_push    = ar_hs && !ar_full;
  assign r_has      = ar_rd_ptr_reg != ar_wr_ptr_reg;
  assign r_head_id  = ar_id_mem[ar_rd_ptr_reg[IDX_W-1:0]];
  assign r_head_len = ar_len_mem[ar_rd_ptr_reg[IDX_W-1:0]];
  assign r_pop      = r_hs && r_has && RLAST;
  assign r_err      = r_hs && (!r_has || (RID != r_head_id) ||
                               (RLAST != (rbeat_reg == {1'b0, r_head_len})));

  always_ff @(posedge clk) begin
    if (ar_push) begin
      ar_id_mem[ar_wr_ptr_reg[IDX_W-1:0]]  <= ARID;
      ar_len_mem[ar_wr_ptr_reg[IDX_W-1:0]] <= ARLEN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_wr_ptr_reg <= '0;
      ar_rd_ptr_reg <= '0;
      rbeat_reg     <= '0;
    end else begin
      if (ar_push) ar_wr_ptr_reg <= ar_wr_ptr_reg + PTR_W'(1);
      if (r_pop)   ar_rd_ptr_reg <= ar_rd_ptr_reg + PTR_W'(1);
      if (r_hs && r_has) begin
        rbeat_reg <= RLAST ? '0 : rbeat_reg + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error collection
  // ---------------------------------------------------------------------------
  logic       ovf_err;
  logic [9:0] new_err;
  logic [3:0] first_next;
  logic [9:0] err_sticky_reg;
  logic [3:0] first_err_reg;
  logic [7:0] err_cnt_reg;

  // An overflowing request is dropped: its push is already suppressed above.
  assign ovf_err = (aw_hs && aw_full) || (ar_hs && ar_full);
  assign new_err = chk_en ? {ovf_err, r_err, b_err, w_orphan_err, w_last_err, stab_err}
                          : 10'd0;

  // Lowest set index wins when several errors arrive together.
  always_comb begin
    first_next = 4'hF;
    for (int i = 9; i >= 0; i--) begin
      if (new_err[i]) first_next = 4'(i);
    end
  end

  // A new error beats a coincident clear: the clear wipes history, then the
  // new error is recorded as if it were the first one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_reg <= '0;
      first_err_reg  <= 4'hF;
      err_cnt_reg    <= '0;
    end else if (new_err != 10'd0) begin
      if (err_clr) begin
        err_sticky_reg <= new_err;
        first_err_reg  <= first_next;
        err_cnt_reg    <= 8'd1;
      end else begin
        err_sticky_reg <= err_sticky_reg | new_err;
        if (first_err_reg == 4'hF) first_err_reg <= first_next;
        if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end else if (err_clr) begin
      err_sticky_reg <= '0;
      first_err_reg  <= 4'hF;
      err_cnt_reg    <= '0;
    end
  end

  assign err_sticky = err_sticky_reg;
  assign err_any    = |err_sticky_reg;
  assign first_err  = first_err_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: doc/axi4_protocol_checker.md
Name: axi4_protocol_checker

Overview:
- Synthesizable, parametrised AXI4 protocol checker; passively taps all five channels of one master/slave link and raises sticky error flags.
- Usable in silicon debug and under any simulator.
- Adds VALID/payload stability checks on every channel.
- Adds burst-length (xLAST) checking, in-order ID matching, response-without-request detection and outstanding-transaction overflow detection.
- AXI4 only: no WID; LEN is 8-bit by default.

Parameters:
- ID_WIDTH, 9: width of AWID/BID/ARID/RID.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; WSTRB is DATA_WIDTH/8.
- LEN_WIDTH, 8: AxLEN width.
- MAX_OUTSTANDING, 8: per-direction tracking FIFO depth; power of two, 2 or more.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- chk_en  input  1  enable; while 0, no error bit sets, but tracking continues.
- err_clr  input  1  clears err_sticky, first_err and err_cnt.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  input  ID_WIDTH/ADDR_WIDTH/LEN_WIDTH/3/2  write-address payload.
- AWVALID, AWREADY  input  1 each  write-address handshake.
- WDATA/WSTRB/WLAST  input  DATA_WIDTH/DATA_WIDTH/8/1  write-data payload.
- WVALID, WREADY  input  1 each  write-data handshake.
- BID/BRESP  input  ID_WIDTH/2  write-response payload.
- BVALID, BREADY  input  1 each  write-response handshake.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  input  ID_WIDTH/ADDR_WIDTH/LEN_WIDTH/3/2  read-address payload.
- ARVALID, ARREADY  input  1 each  read-address handshake.
- RID/RDATA/RRESP/RLAST  input  ID_WIDTH/DATA_WIDTH/2/1  read-data payload.
- RVALID, RREADY  input  1 each  read-data handshake.
- err_sticky  output  10  sticky error bits; indices listed below.
- err_any  output  1  OR of err_sticky.
- first_err  output  4  index of first error since reset/clear; 4'hF = none.
- err_cnt  output  8  count of cycles with at least one new error; saturates at 255.

Behaviour:
- Reset: all outputs 0 except first_err = 4'hF. All pointers, counters and hold registers cleared.
- Reset mid-burst discards all tracking. Stability is not checked on the first cycle after rst.
- Handshake: a transfer occurs on a cycle where VALID && READY.
- Errors are evaluated at posedge from sampled inputs and are visible on outputs 1 cycle later.
- Stability, per channel: hold registers capture VALID && !READY plus the payload each cycle. If the previous cycle had VALID && !READY, then VALID must be 1 now and the payload must equal the held copy.
  - Violation bits: 0 = AW, 1 = W, 2 = B, 3 = AR, 4 = R.
- Write tracking: AW FIFO of {AWID, AWLEN}, written on AW handshake.
  - Two read pointers: w_ptr advances on W handshake with WLAST; b_ptr advances (pop) on B handshake.
  - Beat counter wbeat resets to 0 after a WLAST handshake.
- Bit 5, WLAST mismatch: on a W handshake with w_ptr != wr_ptr, error if (WLAST && wbeat != len) or (!WLAST && wbeat == len). The pointer still advances on WLAST.
- Bit 6, W without AW: W handshake while w_ptr == wr_ptr. AW must precede or coincide with W; a same-cycle AW handshake counts as preceding.
- Bit 7, bad B: B handshake while b_ptr == w_ptr, or BID != stored AWID at b_ptr. Responses are in order.
- Read tracking: AR FIFO of {ARID, ARLEN}; rbeat counter.
- Bit 8, bad R: any of the following on an R handshake:
  - FIFO empty (same-cycle AR does not count);
  - RID != head ID;
  - RLAST mismatch, same rule as WLAST.
  - Pop on RLAST.
- Bit 9, overflow: AW handshake with AW FIFO full, or AR handshake with AR FIFO full. The overflowing entry is dropped and the pointers do not move.
- Counters are LEN_WIDTH+1 bits wide; len = 255 allows 256 beats without wrap.
- Multiple new errors in one cycle: all bits set; first_err takes the lowest index; err_cnt increments by 1.
- err_clr in the same cycle as a new error: the new error wins, and first_err/err_cnt reflect only that error.

Test Plan:
- Legal traffic: AW ID=3 LEN=3, 4 W beats with WLAST on beat 4, B ID=3; AR ID=5 LEN=0, R ID=5 RLAST -> err_sticky = 0, first_err = F.
- AWVALID high with AWREADY low; AWADDR changes 0x100 -> 0x104 on the next cycle -> err_sticky[0] = 1, first_err = 0 one cycle later.
- AW LEN=3, WLAST asserted on beat 3 -> bit 5 set. Next AW LEN=1 with 2 correct beats -> no further error; err_cnt = 1.
- BVALID/BREADY with no completed write -> bit 7. Then a completed write with AWID=2 and BID=4 -> err_cnt = 2.
- MAX_OUTSTANDING=8: 9 AR handshakes with no R -> bit 9 on the 9th. Then 8 in-order R responses -> no bit 8.
- Error at the same cycle as err_clr -> only that bit remains set, err_cnt = 1. rst mid-burst, then a fresh legal burst -> no errors.
